// File: rtl/capture_trigger.sv
// Pre/post-trigger sample capture controller for an ADC display front end.
// A circular sample RAM holds MAX_SAMPLES words. PRE_TRIG samples before the
// trigger are kept, and the trigger sample itself is window index PRE_TRIG.
module capture_trigger #(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned MAX_SAMPLES  = 600,
  parameter int unsigned PRE_TRIG     = 100,
  parameter int unsigned HYST         = 8,
  parameter int unsigned AUTO_TIMEOUT = 4096
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    sample_valid_i,
  input  logic [SAMPLE_WIDTH-1:0] sample_i,
  input  logic [SAMPLE_WIDTH-1:0] trig_level_i,
  input  logic                    trig_edge_i,
  input  logic [1:0]              trig_mode_i,
  input  logic                    arm_ok_i,
  input  logic                    frame_start_i,
  input  logic                    rearm_i,
  output logic                    wr_en_o,
  output logic [ADDR_WIDTH-1:0]   wr_addr_o,
  output logic [SAMPLE_WIDTH-1:0] wr_data_o,
  output logic [ADDR_WIDTH-1:0]   start_addr_o,
  output logic                    done_o,
  output logic                    auto_fired_o,
  output logic                    busy_o,
  output logic [15:0]             trig_count_o
);

  localparam int unsigned CntW    = ADDR_WIDTH + 1;
  localparam int unsigned ToW     = $clog2(AUTO_TIMEOUT + 1);
  localparam int unsigned PostLen = MAX_SAMPLES - PRE_TRIG;

  localparam logic [CntW-1:0]       PreTrigC = CntW'(PRE_TRIG);
  localparam logic [CntW-1:0]       PostLenC = CntW'(PostLen);
  localparam logic [ToW-1:0]        TimeoutC = ToW'(AUTO_TIMEOUT);
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(MAX_SAMPLES - 1);
  localparam logic [ADDR_WIDTH-1:0] PreTrigA = ADDR_WIDTH'(PRE_TRIG);
  localparam logic [ADDR_WIDTH-1:0] PostLenA = ADDR_WIDTH'(PostLen);
  localparam logic [SAMPLE_WIDTH:0] HystC    = (SAMPLE_WIDTH + 1)'(HYST);

  typedef enum logic [2:0] {
    StIdle, StPretrig, StArmed, StPost, StDone, StHold
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [CntW-1:0]         pre_q, pre_d;
  logic [CntW-1:0]         post_q, post_d;
  logic [ToW-1:0]          to_q, to_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [SAMPLE_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [ADDR_WIDTH-1:0]   start_q, start_d;
  logic                    done_q, done_d;
  logic                    auto_q, auto_d;
  logic [15:0]             count_q, count_d;

  // Hysteresis thresholds: one bit wider so under/overflow can saturate.
  logic [SAMPLE_WIDTH:0]   level_ext, lo_ext, hi_ext;
  logic [SAMPLE_WIDTH-1:0] arm_lo, arm_hi;
  logic                    arm_cond, trig_hit, auto_mode, capture;
  logic                    natural_trig, force_trig;
  logic [ADDR_WIDTH-1:0]   ptr_nxt, start_calc;
  logic [CntW-1:0]         post_inc;

  assign level_ext  = {1'b0, trig_level_i};
  assign lo_ext     = level_ext - HystC;
  assign hi_ext     = level_ext + HystC;
  assign arm_lo     = lo_ext[SAMPLE_WIDTH] ? '0 : lo_ext[SAMPLE_WIDTH-1:0];
  assign arm_hi     = hi_ext[SAMPLE_WIDTH] ? '1 : hi_ext[SAMPLE_WIDTH-1:0];
  assign arm_cond   = trig_edge_i ? (sample_i > arm_hi) : (sample_i < arm_lo);
  assign trig_hit   = trig_edge_i ? (sample_i <= trig_level_i) : (sample_i >= trig_level_i);
  assign auto_mode  = (trig_mode_i == 2'b01);
  assign capture    = (state_q == StPretrig) || (state_q == StArmed) || (state_q == StPost);
  assign ptr_nxt    = (ptr_q == LastAddr) ? '0 : ptr_q + 1'b1;
  assign start_calc = (ptr_q >= PreTrigA) ? ptr_q - PreTrigA : ptr_q + PostLenA;
  assign post_inc   = post_q + 1'b1;

  assign natural_trig = (state_q == StArmed) && trig_hit;
  // Auto trigger needs a full pre-trigger history so the window is never short.
  assign force_trig   = auto_mode && (to_q == TimeoutC) && (pre_q == PreTrigC);

  // Next-state, RAM write and status update logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    pre_d     = pre_q;
    post_d    = post_q;
    to_d      = to_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    start_d   = start_q;
    done_d    = done_q;
    auto_d    = auto_q;
    count_d   = count_q;

    if (capture && sample_valid_i) begin
      wr_en_d   = 1'b1;
      wr_addr_d = ptr_q;
      wr_data_d = sample_i;
      ptr_d     = ptr_nxt;
    end

    unique case (state_q)
      StIdle: begin
        if (arm_ok_i) begin
          state_d = StPretrig;
          ptr_d   = '0;
          pre_d   = '0;
          post_d  = '0;
          to_d    = '0;
          done_d  = 1'b0;
          auto_d  = 1'b0;
        end
      end
      StPretrig, StArmed: begin
        if (!auto_mode) to_d = '0;
        if (sample_valid_i) begin
          if (pre_q != PreTrigC) pre_d = pre_q + 1'b1;
          if (natural_trig || force_trig) begin
            start_d = start_calc;
            count_d = count_q + 16'd1;
            post_d  = {{(CntW-1){1'b0}}, 1'b1};
            auto_d  = auto_q | !natural_trig;
            if (PostLenC == {{(CntW-1){1'b0}}, 1'b1}) begin
              state_d = StDone;
              done_d  = 1'b1;
            end else begin
              state_d = StPost;
            end
          end else begin
            if ((state_q == StPretrig) && (pre_q == PreTrigC) && arm_cond) state_d = StArmed;
            if (auto_mode && (to_q != TimeoutC)) to_d = to_q + 1'b1;
          end
        end
      end
      StPost: begin
        if (sample_valid_i) begin
          post_d = post_inc;
          if (post_inc == PostLenC) begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end
      end
      StDone: begin
        if (frame_start_i) state_d = (trig_mode_i == 2'b10) ? StHold : StIdle;
      end
      StHold: begin
        if (rearm_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      pre_q     <= '0;
      post_q    <= '0;
      to_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      start_q   <= '0;
      done_q    <= 1'b0;
      auto_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      pre_q     <= pre_d;
      post_q    <= post_d;
      to_q      <= to_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      start_q   <= start_d;
      done_q    <= done_d;
      auto_q    <= auto_d;
      count_q   <= count_d;
    end
  end

  assign wr_en_o      = wr_en_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign start_addr_o = start_q;
  assign done_o       = done_q;
  assign auto_fired_o = auto_q;
  assign busy_o       = capture;
  assign trig_count_o = count_q;

endmodule

// File: tb/tb_capture_trigger.sv
// Directed bench for capture_trigger with a window-index model and per-cycle compare.
module tb_capture_trigger;

  localparam int AW   = 10;
  localparam int SW   = 16;
  localparam int MAXS = 600;
  localparam int PRE  = 100;
  localparam int HYS  = 8;
  localparam int TMO  = 64;

  localparam int PIdle = 0, PPre = 1, PArm = 2, PPost = 3, PDone = 4, PHold = 5;

  logic          clk_i = 1'b0;
  logic          reset_n_i = 1'b0;
  logic          sample_valid_i = 1'b0;
  logic [SW-1:0] sample_i = '0;
  logic [SW-1:0] trig_level_i = '0;
  logic          trig_edge_i = 1'b0;
  logic [1:0]    trig_mode_i = 2'b00;
  logic          arm_ok_i = 1'b0;
  logic          frame_start_i = 1'b0;
  logic          rearm_i = 1'b0;
  logic          wr_en_o;
  logic [AW-1:0] wr_addr_o;
  logic [SW-1:0] wr_data_o;
  logic [AW-1:0] start_addr_o;
  logic          done_o;
  logic          auto_fired_o;
  logic          busy_o;
  logic [15:0]   trig_count_o;

  int checks = 0;
  int failures = 0;

  capture_trigger #(
    .ADDR_WIDTH  (AW),
    .SAMPLE_WIDTH(SW),
    .MAX_SAMPLES (MAXS),
    .PRE_TRIG    (PRE),
    .HYST        (HYS),
    .AUTO_TIMEOUT(TMO)
  ) u_dut (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .sample_valid_i(sample_valid_i),
    .sample_i      (sample_i),
    .trig_level_i  (trig_level_i),
    .trig_edge_i   (trig_edge_i),
    .trig_mode_i   (trig_mode_i),
    .arm_ok_i      (arm_ok_i),
    .frame_start_i (frame_start_i),
    .rearm_i       (rearm_i),
    .wr_en_o       (wr_en_o),
    .wr_addr_o     (wr_addr_o),
    .wr_data_o     (wr_data_o),
    .start_addr_o  (start_addr_o),
    .done_o        (done_o),
    .auto_fired_o  (auto_fired_o),
    .busy_o        (busy_o),
    .trig_count_o  (trig_count_o)
  );

  always #5 clk_i = ~clk_i;

  // Model: phase, absolute sample index within the capture, trigger index.
  int m_phase = PIdle, m_n = 0, m_seen = 0, m_trig = 0;
  bit m_live = 1'b0;
  bit e_wr_en = 1'b0, e_done = 1'b0, e_auto = 1'b0;
  int e_wr_addr = 0, e_wr_data = 0, e_start = 0, e_count = 0;

  task automatic model_step();
    int  s, lvl, lo, hi;
    bit  armc, hit, frc, trg;
    if (!reset_n_i) begin
      m_phase = PIdle; m_n = 0; m_seen = 0; m_trig = 0;
      e_wr_en = 0; e_wr_addr = 0; e_wr_data = 0; e_start = 0;
      e_done = 0; e_auto = 0; e_count = 0;
      return;
    end
    e_wr_en = 0;
    s   = int'(sample_i);
    lvl = int'(trig_level_i);
    lo  = (lvl - HYS < 0) ? 0 : lvl - HYS;
    hi  = (lvl + HYS > 65535) ? 65535 : lvl + HYS;
    armc = trig_edge_i ? (s > hi) : (s < lo);
    hit  = trig_edge_i ? (s <= lvl) : (s >= lvl);
    case (m_phase)
      PIdle: if (arm_ok_i) begin
        m_phase = PPre; m_n = 0; m_seen = 0; e_done = 0; e_auto = 0;
      end
      PPre, PArm: begin
        if (trig_mode_i != 2'b01) m_seen = 0;
        if (sample_valid_i) begin
          e_wr_en = 1; e_wr_addr = m_n % MAXS; e_wr_data = s;
          frc = (trig_mode_i == 2'b01) && (m_seen >= TMO) && (m_n >= PRE);
          trg = 0;
          if (m_phase == PArm && hit) trg = 1;
          else if (frc) begin trg = 1; e_auto = 1; end
          else if (m_phase == PPre && m_n >= PRE && armc) m_phase = PArm;
          if (trg) begin
            m_trig  = m_n;
            e_start = (m_n - PRE) % MAXS;
            e_count = (e_count + 1) % 65536;
            m_phase = PPost;
            if (MAXS - PRE == 1) begin m_phase = PDone; e_done = 1; end
          end else if (trig_mode_i == 2'b01) begin
            m_seen++;
          end
          m_n++;
        end
      end
      PPost: if (sample_valid_i) begin
        e_wr_en = 1; e_wr_addr = m_n % MAXS; e_wr_data = s;
        m_n++;
        if (m_n - m_trig == MAXS - PRE) begin m_phase = PDone; e_done = 1; end
      end
      PDone: if (frame_start_i) m_phase = (trig_mode_i == 2'b10) ? PHold : PIdle;
      PHold: if (rearm_i) m_phase = PIdle;
      default: m_phase = PIdle;
    endcase
  endtask

  // Per-cycle compare of every output against the model.
  always @(negedge clk_i) begin
    if (m_live) begin
      bit e_busy;
      e_busy = (m_phase >= PPre) && (m_phase <= PPost);
      checks++;
      if (wr_en_o !== e_wr_en || wr_addr_o !== AW'(e_wr_addr) || wr_data_o !== SW'(e_wr_data)
          || start_addr_o !== AW'(e_start) || done_o !== e_done || auto_fired_o !== e_auto
          || busy_o !== e_busy || trig_count_o !== 16'(e_count)) begin
        failures++;
        $display("FAIL model_cmp t=%0t act en=%0b addr=%0d data=%0d start=%0d done=%0b auto=%0b busy=%0b cnt=%0d req en=%0b addr=%0d data=%0d start=%0d done=%0b auto=%0b busy=%0b cnt=%0d",
                 $time, wr_en_o, wr_addr_o, wr_data_o, start_addr_o, done_o, auto_fired_o,
                 busy_o, trig_count_o, e_wr_en, e_wr_addr, e_wr_data, e_start, e_done, e_auto,
                 e_busy, e_count);
      end
    end
  end

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s act=%0d req=%0d", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    model_step();
    m_live = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic feed(input int v);
    sample_valid_i = 1'b1; sample_i = SW'(v); cyc();
    sample_valid_i = 1'b0;
  endtask

  task automatic pulse_arm();
    arm_ok_i = 1'b1; cyc(); arm_ok_i = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_start_i = 1'b1; cyc(); frame_start_i = 1'b0;
  endtask

  task automatic pulse_rearm();
    rearm_i = 1'b1; cyc(); rearm_i = 1'b0;
  endtask

  task automatic ramp(input int last, input bool_gaps);
    for (int i = 0; i <= last; i++) begin
      feed(i);
      if (bool_gaps != 0 && i % 5 == 4) cyc();
    end
  endtask

  initial begin
    @(negedge clk_i);
    reset_n_i = 1'b0;
    repeat (3) cyc();
    lit("reset_wr_en", 32'(wr_en_o), 0);
    lit("reset_busy", 32'(busy_o), 0);
    lit("reset_count", 32'(trig_count_o), 0);
    lit("reset_done", 32'(done_o), 0);
    reset_n_i = 1'b1;

    // Rising ramp, normal mode; the sample alongside arm_ok must not be written.
    trig_level_i = 16'd300; trig_edge_i = 1'b0; trig_mode_i = 2'b00;
    arm_ok_i = 1'b1; sample_valid_i = 1'b1; sample_i = 16'd7777; cyc();
    arm_ok_i = 1'b0; sample_valid_i = 1'b0;
    lit("arm_no_write", 32'(wr_en_o), 0);
    ramp(1023, 1);
    lit("ramp_done", 32'(done_o), 1);
    lit("ramp_count", 32'(trig_count_o), 1);
    lit("ramp_start", 32'(start_addr_o), 200);
    lit("ramp_busy", 32'(busy_o), 0);
    pulse_rearm();
    pulse_arm();
    lit("done_ignores_rearm", 32'(busy_o), 0);
    pulse_frame();
    lit("idle_keeps_done", 32'(done_o), 1);

    // Auto mode on a flat signal above the level: forced trigger.
    trig_mode_i = 2'b01;
    pulse_arm();
    for (int i = 0; i < 610; i++) feed(500);
    lit("auto_fired", 32'(auto_fired_o), 1);
    lit("auto_start", 32'(start_addr_o), 0);
    lit("auto_count", 32'(trig_count_o), 2);
    pulse_frame();

    // Mode 11 behaves as normal: flat signal never triggers.
    trig_mode_i = 2'b11;
    pulse_arm();
    lit("arm_clears_auto", 32'(auto_fired_o), 0);
    lit("arm_clears_done", 32'(done_o), 0);
    for (int i = 0; i < 300; i++) feed(500);
    lit("normal_busy", 32'(busy_o), 1);
    lit("normal_no_trig", 32'(trig_count_o), 2);

    // Falling edge with noise inside the hysteresis band.
    trig_edge_i = 1'b1;
    for (int i = 0; i < 50; i++) feed(300 + ((i * 7) % 9) - 4);
    lit("noise_no_trig", 32'(trig_count_o), 2);
    feed(309); feed(305); feed(302); feed(301);
    lit("armed_no_trig", 32'(trig_count_o), 2);
    feed(300);
    lit("fall_count", 32'(trig_count_o), 3);
    lit("fall_start", 32'(start_addr_o), 254);
    for (int i = 0; i < 499; i++) feed(200);
    lit("fall_done", 32'(done_o), 1);

    // Single mode: hold across frame pulses and arm_ok until rearm.
    trig_mode_i = 2'b10;
    pulse_frame();
    pulse_frame();
    lit("hold_done", 32'(done_o), 1);
    arm_ok_i = 1'b1;
    for (int i = 0; i < 3; i++) feed(10);
    arm_ok_i = 1'b0;
    lit("hold_busy", 32'(busy_o), 0);
    pulse_rearm();
    pulse_arm();
    lit("rearm_busy", 32'(busy_o), 1);
    lit("rearm_done", 32'(done_o), 0);

    // Reset during the post-trigger phase, then a clean full capture.
    trig_mode_i = 2'b00; trig_edge_i = 1'b0;
    ramp(400, 0);
    lit("post_count", 32'(trig_count_o), 4);
    lit("post_busy", 32'(busy_o), 1);
    reset_n_i = 1'b0; cyc(); reset_n_i = 1'b1;
    lit("rst_busy", 32'(busy_o), 0);
    lit("rst_count", 32'(trig_count_o), 0);
    lit("rst_addr", 32'(wr_addr_o), 0);
    lit("rst_start", 32'(start_addr_o), 0);
    pulse_arm();
    ramp(1023, 0);
    lit("rerun_count", 32'(trig_count_o), 1);
    lit("rerun_start", 32'(start_addr_o), 200);
    lit("rerun_done", 32'(done_o), 1);
    pulse_frame();

    // Long wait before trigger: pointer wraps, start address modulo window.
    trig_level_i = 16'd1000;
    pulse_arm();
    for (int i = 0; i < 601; i++) feed(0);
    lit("wrap_addr", 32'(wr_addr_o), 0);
    for (int i = 601; i < 1000; i++) feed(0);
    feed(1000);
    lit("wrap_trig_addr", 32'(wr_addr_o), 400);
    lit("wrap_start", 32'(start_addr_o), 300);
    for (int i = 0; i < 499; i++) feed(5);
    lit("wrap_done", 32'(done_o), 1);
    lit("wrap_count", 32'(trig_count_o), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/capture_trigger.md
CAPTURE_TRIGGER -- requirements
Module: capture_trigger

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, sample buffer address width.
REQ-002 SHALL have parameter SAMPLE_WIDTH, default 16, sample bit width.
REQ-003 SHALL have parameter MAX_SAMPLES, default 600, capture window length; MAX_SAMPLES <= 2**ADDR_WIDTH.
REQ-004 SHALL have parameter PRE_TRIG, default 100, samples kept before trigger; PRE_TRIG < MAX_SAMPLES.
REQ-005 SHALL have parameter HYST, default 8, arm hysteresis in sample LSBs.
REQ-006 SHALL have parameter AUTO_TIMEOUT, default 4096, samples before auto mode forces a trigger.
REQ-007 SHALL have ports: clk input 1, sole clock; reset_n input 1, synchronous active-low reset.
REQ-008 SHALL have ports: sample_valid input 1, new ADC sample strobe; sample input SAMPLE_WIDTH, ADC data.
REQ-009 SHALL have ports: trig_level input SAMPLE_WIDTH; trig_edge input 1 (0 rising, 1 falling); trig_mode input 2 (00 normal, 01 auto, 10 single, 11 treated as normal).
REQ-010 SHALL have ports: arm_ok input 1, display blanking (capture may start); frame_start input 1, one-cycle top-of-frame pulse; rearm input 1, single-mode re-arm pulse.
REQ-011 SHALL have ports: wr_en output 1; wr_addr output ADDR_WIDTH; wr_data output SAMPLE_WIDTH, to sample RAM.
REQ-012 SHALL have ports: start_addr output ADDR_WIDTH, RAM address of oldest window sample; done output 1, window valid; auto_fired output 1; busy output 1; trig_count output 16.

Function
REQ-013 SHALL implement states IDLE, PRETRIG, ARMED, POST, DONE, HOLD.
REQ-014 IDLE -> PRETRIG when arm_ok=1; done cleared on that transition; write pointer and counters zeroed.
REQ-015 In PRETRIG, ARMED, POST, each sample_valid cycle SHALL register wr_en=1, wr_data=sample, wr_addr=pointer (one-cycle latency); otherwise wr_en=0.
REQ-016 Write pointer SHALL increment per written sample and wrap MAX_SAMPLES-1 -> 0.
REQ-017 PRETRIG -> ARMED once PRE_TRIG samples written AND arm condition seen on a valid sample: rising, sample < trig_level-HYST (saturate at 0); falling, sample > trig_level+HYST (saturate at all-ones).
REQ-018 ARMED -> POST on valid sample meeting trigger: rising sample >= trig_level; falling sample <= trig_level; that sample is written and is window index PRE_TRIG.
REQ-019 On trigger, start_addr SHALL latch (trigger address - PRE_TRIG) mod MAX_SAMPLES and trig_count SHALL increment, wrapping at 16 bits.
REQ-020 POST SHALL write MAX_SAMPLES-PRE_TRIG samples including trigger sample, then assert done=1 and go DONE.
REQ-021 DONE -> IDLE on frame_start, except trig_mode=10 -> HOLD.
REQ-022 HOLD -> IDLE on rearm; frame_start ignored; rearm outside HOLD ignored.
REQ-023 Auto mode: timeout counter counts valid samples in PRETRIG/ARMED; at AUTO_TIMEOUT with >= PRE_TRIG written, next valid sample forces trigger, auto_fired=1; auto_fired cleared on IDLE -> PRETRIG.
REQ-024 Normal/single mode SHALL never force trigger; timeout counter held at 0.
REQ-025 busy=1 in PRETRIG, ARMED, POST; else 0.
REQ-026 trig_level, trig_edge, trig_mode SHALL be sampled every cycle; changes take effect next comparison.
REQ-027 arm_ok deassert mid-capture SHALL NOT abort capture.
REQ-028 Trigger and arm conditions SHALL use unsigned comparison at SAMPLE_WIDTH; hysteresis sums computed one bit wider then saturated.

Reset
REQ-029 reset_n=0 at clk edge SHALL force IDLE, wr_en=0, wr_addr=0, wr_data=0, start_addr=0, done=0, auto_fired=0, busy=0, trig_count=0, all counters 0, including mid-capture.
REQ-030 First post-reset write SHALL occur no earlier than the cycle after arm_ok seen high in IDLE.

Verification
REQ-031 Rising ramp 0..1023 step 1, trig_level=300, normal -> trigger on sample 300, start_addr=(addr of 300 - 100) mod 600, done after 500 more writes, trig_count=1.
REQ-032 Constant 500, trig_level=300, auto, AUTO_TIMEOUT=64 -> forced trigger after 64 valid samples, auto_fired=1; same in normal -> never triggers, busy stays 1.
REQ-033 Falling edge, noise ±4 around 300, HYST=8 -> no trigger until sample > 308 then <= 300.
REQ-034 Single mode, two frame_start pulses after done -> stays HOLD, done=1; rearm -> IDLE, new capture on arm_ok.
REQ-035 reset_n low during POST -> all outputs 0 next cycle; arm_ok high -> full capture, trig_count=1.
REQ-036 1000 samples before trigger with MAX_SAMPLES=600 -> wr_addr wraps 599 -> 0, start_addr correct modulo 600.
